// File: rtl/bpi_port_pkg.sv
// Shared definitions for the VME-to-BPI command port: command codes, DTACK FSM states, port-status bits.
package bpi_port_pkg;

  localparam logic [9:0] CMD_CTRL    = 10'd4;
  localparam logic [9:0] CMD_CFG     = 10'd5;
  localparam logic [9:0] CMD_UL      = 10'd6;
  localparam logic [9:0] CMD_DL      = 10'd7;
  localparam logic [9:0] CMD_RST     = 10'd8;
  localparam logic [9:0] CMD_DSBL    = 10'd9;
  localparam logic [9:0] CMD_ENBL    = 10'd10;
  localparam logic [9:0] CMD_FIFO_WR = 10'd11;
  localparam logic [9:0] CMD_RBK     = 10'd12;
  localparam logic [9:0] CMD_WRDCNT  = 10'd13;
  localparam logic [9:0] CMD_STATUS  = 10'd14;
  localparam logic [9:0] CMD_TMR_LO  = 10'd15;
  localparam logic [9:0] CMD_TMR_HI  = 10'd16;
  localparam logic [9:0] CMD_PSTAT   = 10'd17;
  localparam logic [9:0] CMD_ERRCNT  = 10'd18;

  localparam int PS_OVF = 0;
  localparam int PS_ERR = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_WAIT,
    ST_ACK
  } dtack_state_t;

  // Cmd 18 counts as defined even when the error counter is compiled out.
  function automatic logic cmd_defined(input logic [9:0] cmd);
    return (cmd >= CMD_CTRL) && (cmd <= CMD_ERRCNT);
  endfunction

endpackage

// File: rtl/bpi_vme_dtack_fsm.sv
// VME handshake sequencer: detects the start of a strobe, paces read acknowledges and drives DTACK_B.
module bpi_vme_dtack_fsm
  import bpi_port_pkg::*;
#(
  parameter int DTACK_DLY = 1
) (
  input  logic CLK,
  input  logic RST,
  input  logic device,
  input  logic strobe,
  input  logic cmd_read,
  output logic start,
  output logic decode,
  output wire logic dtack_b
);

  localparam logic [2:0] WAIT_LAST = 3'((DTACK_DLY > 0) ? (DTACK_DLY - 1) : 0);

  logic         busy;
  logic         busy_q;
  logic [2:0]   wait_cnt;
  logic         dtack_en;
  logic         dtack_lvl;
  dtack_state_t state;

  assign busy    = device & strobe;
  assign start   = (state == ST_IDLE) && busy && !busy_q;
  assign decode  = (state == ST_DECODE);
  assign dtack_b = dtack_en ? dtack_lvl : 1'bz;

  // Any fall of busy_q before ACK aborts the transfer without ever acknowledging.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      busy_q    <= 1'b0;
      wait_cnt  <= '0;
      dtack_en  <= 1'b0;
      dtack_lvl <= 1'b1;
    end else begin
      busy_q <= busy;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_DECODE;
            dtack_en  <= 1'b1;
            dtack_lvl <= 1'b1;
          end
        end
        ST_DECODE: begin
          if (!busy_q) begin
            state    <= ST_IDLE;
            dtack_en <= 1'b0;
          end else if (!cmd_read || (DTACK_DLY == 0)) begin
            state     <= ST_ACK;
            dtack_lvl <= 1'b0;
          end else begin
            state    <= ST_WAIT;
            wait_cnt <= '0;
          end
        end
        ST_WAIT: begin
          if (!busy_q) begin
            state    <= ST_IDLE;
            dtack_en <= 1'b0;
          end else if (wait_cnt == WAIT_LAST) begin
            state     <= ST_ACK;
            dtack_lvl <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end
        ST_ACK: begin
          if (!busy_q) begin
            state     <= ST_IDLE;
            dtack_en  <= 1'b0;
            dtack_lvl <= 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          dtack_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/bpi_vme_cmd_port.sv
// VME-to-BPI command port: decodes VME commands into BPI pulses/FIFO writes and muxes readback data.
// Optional error counter on cmd 18 enabled by defining BPI_VME_CMD_PORT_ERR_CNT_EN.
module bpi_vme_cmd_port
  import bpi_port_pkg::*;
#(
  parameter int DW        = 16,
  parameter int NCFG      = 4,
  parameter int TMR_W     = 32,
  parameter int RCNT_W    = 11,
  parameter int DTACK_DLY = 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                DEVICE,
  input  logic                STROBE,
  input  logic [9:0]          COMMAND,
  input  logic                WRITE_B,
  input  logic [DW-1:0]       INDATA,
  output logic [DW-1:0]       OUTDATA,
  output wire logic           DTACK_B,
  output logic                BPI_RST,
  output logic                BPI_DSBL,
  output logic                BPI_ENBL,
  output logic                BPI_WE,
  output logic                BPI_RE,
  output logic                BPI_CFG_UL,
  output logic                BPI_CFG_DL,
  output logic [DW-1:0]       BPI_CMD_FIFO_DATA,
  input  logic                BPI_CMD_FIFO_FULL,
  output logic                BPI_MODE,
  output logic                BPI_CFG_DATA_SEL,
  input  logic [DW-1:0]       BPI_RBK_FIFO_DATA,
  input  logic [RCNT_W-1:0]   BPI_RBK_WRD_CNT,
  input  logic [DW-1:0]       BPI_STATUS,
  input  logic [TMR_W-1:0]    BPI_TIMER,
  input  logic [NCFG*DW-1:0]  BPI_CFG_REGS
);

  localparam int CSW = $clog2(NCFG);

  logic            start;
  logic            decode;
  logic [9:0]      cmd_q;
  logic            rd_q;
  logic [DW-1:0]   wdata_q;
  logic [CSW+1:0]  ctrl;
  logic [DW-1:0]   shadow;
  logic [DW-1:0]   cfg_sel;
  logic [DW-1:0]   rd_mux;
  logic            ovf;
  logic            err;
  logic            ovf_set;
  logic            err_set;
  logic            pstat_clr;

  bpi_vme_dtack_fsm #(.DTACK_DLY(DTACK_DLY)) u_fsm (
    .CLK      (CLK),
    .RST      (RST),
    .device   (DEVICE),
    .strobe   (STROBE),
    .cmd_read (rd_q),
    .start    (start),
    .decode   (decode),
    .dtack_b  (DTACK_B)
  );

  assign BPI_MODE         = ctrl[CSW+1];
  assign BPI_CFG_DATA_SEL = ctrl[CSW];

  assign ovf_set   = decode && (cmd_q == CMD_FIFO_WR) && !rd_q && BPI_CMD_FIFO_FULL;
  assign err_set   = decode && !cmd_defined(cmd_q);
  assign pstat_clr = decode && rd_q && (cmd_q == CMD_PSTAT);

  always_comb begin
    cfg_sel = '0;
    for (int i = 0; i < NCFG; i++) begin
      if (ctrl[CSW-1:0] == CSW'(i)) cfg_sel = BPI_CFG_REGS[i*DW +: DW];
    end
  end

`ifdef BPI_VME_CMD_PORT_ERR_CNT_EN
  logic [7:0] err_cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      err_cnt <= '0;
    end else if ((ovf_set || err_set) && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

  always_comb begin
    rd_mux = '0;
    case (cmd_q)
      CMD_CTRL:   rd_mux[CSW+1:0] = ctrl;
      CMD_CFG:    rd_mux = cfg_sel;
      CMD_RBK:    rd_mux = BPI_RBK_FIFO_DATA;
      CMD_WRDCNT: rd_mux[RCNT_W-1:0] = BPI_RBK_WRD_CNT;
      CMD_STATUS: rd_mux = BPI_STATUS;
      CMD_TMR_LO: rd_mux = BPI_TIMER[DW-1:0];
      CMD_TMR_HI: rd_mux = shadow;
      CMD_PSTAT: begin
        rd_mux[PS_OVF] = ovf;
        rd_mux[PS_ERR] = err;
      end
`ifdef BPI_VME_CMD_PORT_ERR_CNT_EN
      CMD_ERRCNT: rd_mux[7:0] = err_cnt;
`endif
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cmd_q   <= '0;
      rd_q    <= 1'b0;
      wdata_q <= '0;
    end else if (start) begin
      cmd_q   <= COMMAND;
      rd_q    <= WRITE_B;
      wdata_q <= INDATA;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      BPI_RST    <= 1'b0;
      BPI_DSBL   <= 1'b0;
      BPI_ENBL   <= 1'b0;
      BPI_WE     <= 1'b0;
      BPI_RE     <= 1'b0;
      BPI_CFG_UL <= 1'b0;
      BPI_CFG_DL <= 1'b0;
    end else begin
      BPI_CFG_UL <= decode && (cmd_q == CMD_UL);
      BPI_CFG_DL <= decode && (cmd_q == CMD_DL);
      BPI_RST    <= decode && (cmd_q == CMD_RST);
      BPI_DSBL   <= decode && (cmd_q == CMD_DSBL);
      BPI_ENBL   <= decode && (cmd_q == CMD_ENBL);
      BPI_WE     <= decode && (cmd_q == CMD_FIFO_WR) && !rd_q && !BPI_CMD_FIFO_FULL;
      BPI_RE     <= decode && (cmd_q == CMD_RBK) && rd_q;
    end
  end

  // The timer shadow is captured on the low-word read so the high word stays coherent.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      OUTDATA           <= '0;
      BPI_CMD_FIFO_DATA <= '0;
      ctrl              <= '0;
      shadow            <= '0;
    end else if (decode) begin
      if (rd_q) OUTDATA <= rd_mux;
      if (rd_q && (cmd_q == CMD_TMR_LO)) shadow <= BPI_TIMER[TMR_W-1:DW];
      if (!rd_q && (cmd_q == CMD_CTRL)) ctrl <= wdata_q[CSW+1:0];
      if (!rd_q && (cmd_q == CMD_FIFO_WR) && !BPI_CMD_FIFO_FULL) BPI_CMD_FIFO_DATA <= wdata_q;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ovf <= 1'b0;
      err <= 1'b0;
    end else begin
      ovf <= ovf_set || (ovf && !pstat_clr);
      err <= err_set || (err && !pstat_clr);
    end
  end

endmodule

// File: tb/tb_bpi_vme_cmd_port.sv
// Directed scoreboard bench for bpi_vme_cmd_port (DTACK_DLY=3); cmd 18 expectation follows BPI_VME_CMD_PORT_ERR_CNT_EN.
module tb_bpi_vme_cmd_port;

  localparam int DW   = 16;
  localparam int DLY  = 3;
  localparam int MAXW = 20;

  logic         clk = 1'b0;
  logic         rst;
  logic         device, strobe, write_b;
  logic [9:0]   command;
  logic [15:0]  indata;
  logic [15:0]  outdata;
  wire          dtack_b;
  logic         bpi_rst, bpi_dsbl, bpi_enbl, bpi_we, bpi_re, bpi_cfg_ul, bpi_cfg_dl;
  logic [15:0]  fifo_data;
  logic         fifo_full;
  logic         bpi_mode, bpi_dsel;
  logic [15:0]  rbk_data;
  logic [10:0]  wrd_cnt;
  logic [15:0]  status;
  logic [31:0]  timer;
  logic [63:0]  cfg_regs;

  int checks = 0;
  int errors = 0;
  int n_we = 0, n_re = 0, n_ul = 0, n_dl = 0, n_rst = 0, n_dsbl = 0, n_enbl = 0;
  logic [15:0] exp_q[$];
  logic [15:0] last_rd = '0;

  // Released DTACK reads back as 1 through the bus pull-up.
  pullup (dtack_b);

  always #5 clk = ~clk;

  bpi_vme_cmd_port #(.DW(DW), .NCFG(4), .TMR_W(32), .RCNT_W(11), .DTACK_DLY(DLY)) dut (
    .CLK               (clk),
    .RST               (rst),
    .DEVICE            (device),
    .STROBE            (strobe),
    .COMMAND           (command),
    .WRITE_B           (write_b),
    .INDATA            (indata),
    .OUTDATA           (outdata),
    .DTACK_B           (dtack_b),
    .BPI_RST           (bpi_rst),
    .BPI_DSBL          (bpi_dsbl),
    .BPI_ENBL          (bpi_enbl),
    .BPI_WE            (bpi_we),
    .BPI_RE            (bpi_re),
    .BPI_CFG_UL        (bpi_cfg_ul),
    .BPI_CFG_DL        (bpi_cfg_dl),
    .BPI_CMD_FIFO_DATA (fifo_data),
    .BPI_CMD_FIFO_FULL (fifo_full),
    .BPI_MODE          (bpi_mode),
    .BPI_CFG_DATA_SEL  (bpi_dsel),
    .BPI_RBK_FIFO_DATA (rbk_data),
    .BPI_RBK_WRD_CNT   (wrd_cnt),
    .BPI_STATUS        (status),
    .BPI_TIMER         (timer),
    .BPI_CFG_REGS      (cfg_regs)
  );

  always @(negedge clk) begin
    if (bpi_we)     n_we++;
    if (bpi_re)     n_re++;
    if (bpi_cfg_ul) n_ul++;
    if (bpi_cfg_dl) n_dl++;
    if (bpi_rst)    n_rst++;
    if (bpi_dsbl)   n_dsbl++;
    if (bpi_enbl)   n_enbl++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("[TB] %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete VME cycle; read data is queued on drive and popped when DTACK arrives.
  task automatic applyStimulus(input logic [9:0] cmd, input logic wr_b, input logic [15:0] data,
                               input logic [15:0] exp_data, output int lat, output int pulse_at);
    int n;
    logic [15:0] exp;
    n = 0;
    lat = 0;
    pulse_at = 0;
    if (wr_b) exp_q.push_back(exp_data);
    device = 1'b1; strobe = 1'b1; command = cmd; write_b = wr_b; indata = data;
    while (lat == 0 && n < MAXW) begin
      @(posedge clk); #1;
      n++;
      if (pulse_at == 0 && (bpi_rst | bpi_dsbl | bpi_enbl | bpi_we | bpi_re | bpi_cfg_ul | bpi_cfg_dl))
        pulse_at = n;
      if (dtack_b === 1'b0) lat = n;
    end
    checkOutput("dtack_latency", lat, wr_b ? (2 + DLY) : 2);
    if (wr_b) begin
      exp = exp_q.pop_front();
      checkOutput("read_data", outdata, exp);
      last_rd = exp;
    end
    device = 1'b0; strobe = 1'b0;
    n = 0;
    while (dtack_b !== 1'b1 && n < MAXW) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("dtack_release", dtack_b, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int lat, pa, n;
    logic seen_low;
    logic [15:0] exp18;
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lat, pa, n;
    logic seen_low;
    logic [15:0] exp18;
    rst = 1'b1; device = 1'b0; strobe = 1'b0; write_b = 1'b0; command = '0; indata = '0;
    fifo_full = 1'b0; rbk_data = '0; wrd_cnt = '0; status = '0; timer = '0;
    cfg_regs = {16'hD003, 16'hC002, 16'hB001, 16'hA000};
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_outdata", outdata, 0);
    checkOutput("rst_mode", bpi_mode, 0);
    checkOutput("rst_dsel", bpi_dsel, 0);
    checkOutput("rst_fifo_data", fifo_data, 0);
    checkOutput("rst_dtack", dtack_b, 1);
    rst = 1'b0;
    @(posedge clk); #1;

    applyStimulus(10'd11, 1'b0, 16'hA5C3, 16'h0, lat, pa);
    checkOutput("we_at_k1", pa, 2);
    checkOutput("we_count", n_we, 1);
    checkOutput("fifo_data", fifo_data, 16'hA5C3);
    checkOutput("outdata_hold_wr", outdata, last_rd);

    fifo_full = 1'b1;
    applyStimulus(10'd11, 1'b0, 16'h1234, 16'h0, lat, pa);
    fifo_full = 1'b0;
    checkOutput("we_blocked", n_we, 1);
    checkOutput("fifo_data_kept", fifo_data, 16'hA5C3);
    applyStimulus(10'd17, 1'b1, 16'h0, 16'h0001, lat, pa);
    applyStimulus(10'd17, 1'b1, 16'h0, 16'h0000, lat, pa);

    applyStimulus(10'd4, 1'b0, 16'h000E, 16'h0, lat, pa);
    checkOutput("mode", bpi_mode, 1);
    checkOutput("data_sel", bpi_dsel, 1);
    checkOutput("outdata_hold_ctrl", outdata, last_rd);
    applyStimulus(10'd5, 1'b1, 16'h0, 16'hC002, lat, pa);
    applyStimulus(10'd4, 1'b1, 16'h0, 16'h000E, lat, pa);

    timer = 32'h1234FFFF;
    applyStimulus(10'd15, 1'b1, 16'h0, 16'hFFFF, lat, pa);
    timer = 32'h12350000;
    applyStimulus(10'd16, 1'b1, 16'h0, 16'h1234, lat, pa);

    wrd_cnt = 11'h5A5;
    applyStimulus(10'd13, 1'b1, 16'h0, 16'h05A5, lat, pa);
    status = 16'hBEEF;
    applyStimulus(10'd14, 1'b1, 16'h0, 16'hBEEF, lat, pa);
    rbk_data = 16'h7E57;
    applyStimulus(10'd12, 1'b1, 16'h0, 16'h7E57, lat, pa);
    checkOutput("re_at_k1", pa, 2);
    checkOutput("re_count", n_re, 1);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(10'(6 + i), 1'b0, 16'h0, 16'h0, lat, pa);
      checkOutput("pulse_at_k1", pa, 2);
    end
    checkOutput("ul_count", n_ul, 1);
    checkOutput("dl_count", n_dl, 1);
    checkOutput("rst_count", n_rst, 1);
    checkOutput("dsbl_count", n_dsbl, 1);
    checkOutput("enbl_count", n_enbl, 1);

    // Strobe dropped before edge k+2 on a delayed read: no acknowledge ever.
    status = 16'h0F0F;
    device = 1'b1; strobe = 1'b1; command = 10'd14; write_b = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    device = 1'b0; strobe = 1'b0;
    seen_low = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (dtack_b === 1'b0) seen_low = 1'b1;
    end
    checkOutput("abort_no_dtack", seen_low, 0);
    checkOutput("abort_idle", dtack_b, 1);
    applyStimulus(10'd14, 1'b1, 16'h0, 16'h0F0F, lat, pa);

    // Reset while DTACK is held low.
    device = 1'b1; strobe = 1'b1; command = 10'd14; write_b = 1'b1;
    n = 0;
    while (dtack_b !== 1'b0 && n < MAXW) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("ack_before_rst", dtack_b, 0);
    rst = 1'b1;
    #1;
    checkOutput("rst_dtack_release", dtack_b, 1);
    checkOutput("rst_outdata_clr", outdata, 0);
    checkOutput("rst_mode_clr", bpi_mode, 0);
    device = 1'b0; strobe = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    last_rd = '0;
    @(posedge clk); #1;

`ifdef BPI_VME_CMD_PORT_ERR_CNT_EN
    exp18 = 16'h0002;
`else
    exp18 = 16'h0000;
`endif
    applyStimulus(10'd30, 1'b1, 16'h0, 16'h0000, lat, pa);
    applyStimulus(10'd30, 1'b1, 16'h0, 16'h0000, lat, pa);
    applyStimulus(10'd18, 1'b1, 16'h0, exp18, lat, pa);
    applyStimulus(10'd17, 1'b1, 16'h0, 16'h0002, lat, pa);
    applyStimulus(10'd17, 1'b1, 16'h0, 16'h0000, lat, pa);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
